// File: rtl/channel_4_noise_controller.sv
// Noise-channel control unit: holds the four noise registers, runs the
// envelope and length-counter units from frame-sequencer strobes, and drives
// phase delta, LFSR mode and volume into the noise datapath.
//
// Write handshake: i_wr_stb is a single-cycle qualifier with no back-pressure;
// i_wr_addr/i_wr_data are sampled on the i_clk edge where i_wr_stb is high and
// the write is always accepted on that edge.
module channel_4_noise_controller #(
  parameter int CLK_HZ = 25_000_000,
  parameter int CPU_HZ = 1_789_773
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_stb,
  input  logic [1:0]  i_wr_addr,
  input  logic [7:0]  i_wr_data,
  input  logic        i_quarter_stb,
  input  logic        i_half_stb,
  input  logic        i_channel_en,
  output logic [31:0] o_phase_delta,
  output logic        o_mode,
  output logic [3:0]  o_volume,
  output logic        o_active
);

  // Noise timer periods in APU clocks, indexed by the 4-bit period index.
  function automatic logic [63:0] period_of(input int idx);
    case (idx)
      0:       period_of = 64'd4;
      1:       period_of = 64'd8;
      2:       period_of = 64'd16;
      3:       period_of = 64'd32;
      4:       period_of = 64'd64;
      5:       period_of = 64'd96;
      6:       period_of = 64'd128;
      7:       period_of = 64'd160;
      8:       period_of = 64'd202;
      9:       period_of = 64'd254;
      10:      period_of = 64'd380;
      11:      period_of = 64'd508;
      12:      period_of = 64'd762;
      13:      period_of = 64'd1016;
      14:      period_of = 64'd2034;
      default: period_of = 64'd4068;
    endcase
  endfunction

  // Length-counter load values, indexed by the 5-bit length index.
  function automatic logic [7:0] len_of(input logic [4:0] idx);
    case (idx)
      5'd0:    len_of = 8'd10;
      5'd1:    len_of = 8'd254;
      5'd2:    len_of = 8'd20;
      5'd3:    len_of = 8'd2;
      5'd4:    len_of = 8'd40;
      5'd5:    len_of = 8'd4;
      5'd6:    len_of = 8'd80;
      5'd7:    len_of = 8'd6;
      5'd8:    len_of = 8'd160;
      5'd9:    len_of = 8'd8;
      5'd10:   len_of = 8'd60;
      5'd11:   len_of = 8'd10;
      5'd12:   len_of = 8'd14;
      5'd13:   len_of = 8'd12;
      5'd14:   len_of = 8'd26;
      5'd15:   len_of = 8'd14;
      5'd16:   len_of = 8'd12;
      5'd17:   len_of = 8'd16;
      5'd18:   len_of = 8'd24;
      5'd19:   len_of = 8'd18;
      5'd20:   len_of = 8'd48;
      5'd21:   len_of = 8'd20;
      5'd22:   len_of = 8'd96;
      5'd23:   len_of = 8'd22;
      5'd24:   len_of = 8'd192;
      5'd25:   len_of = 8'd24;
      5'd26:   len_of = 8'd72;
      5'd27:   len_of = 8'd26;
      5'd28:   len_of = 8'd16;
      5'd29:   len_of = 8'd28;
      5'd30:   len_of = 8'd32;
      default: len_of = 8'd30;
    endcase
  endfunction

  // Phase increment per system clock, folded to constants at elaboration.
  logic [31:0] delta_rom [16];
  for (genvar g = 0; g < 16; g++) begin : g_delta
    localparam logic [63:0] DELTA_64 =
      ((64'd1 << 32) * 64'(CPU_HZ)) / (period_of(g) * 64'(CLK_HZ));
    assign delta_rom[g] = DELTA_64[31:0];
  end

  // Register state
  logic       halt_q;
  logic       const_q;
  logic [3:0] vol_v_q;
  logic       mode_q;
  logic [3:0] period_idx_q;

  // Envelope and length state
  logic       start_q;
  logic [3:0] divider_q;
  logic [3:0] decay_q;
  logic [7:0] length_q;

  logic wr0;
  logic wr2;
  logic wr3;

  assign wr0 = i_wr_stb && (i_wr_addr == 2'd0);
  assign wr2 = i_wr_stb && (i_wr_addr == 2'd2);
  assign wr3 = i_wr_stb && (i_wr_addr == 2'd3);

  // CPU-visible register file; addr1 and addr3 bits [2:0] have no storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      halt_q       <= 1'b0;
      const_q      <= 1'b0;
      vol_v_q      <= 4'd0;
      mode_q       <= 1'b0;
      period_idx_q <= 4'd0;
    end else begin
      if (wr0) begin
        halt_q  <= i_wr_data[5];
        const_q <= i_wr_data[4];
        vol_v_q <= i_wr_data[3:0];
      end
      if (wr2) begin
        mode_q       <= i_wr_data[7];
        period_idx_q <= i_wr_data[3:0];
      end
    end
  end

  // Envelope unit; an addr3 write re-arms start after the quarter step has
  // already consumed the old start flag on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_q   <= 1'b0;
      divider_q <= 4'd0;
      decay_q   <= 4'd0;
    end else begin
      if (i_quarter_stb) begin
        if (start_q) begin
          start_q   <= 1'b0;
          decay_q   <= 4'd15;
          divider_q <= vol_v_q;
        end else if (divider_q == 4'd0) begin
          divider_q <= vol_v_q;
          if (decay_q != 4'd0) begin
            decay_q <= decay_q - 4'd1;
          end else if (halt_q) begin
            decay_q <= 4'd15;
          end
        end else begin
          divider_q <= divider_q - 4'd1;
        end
      end
      if (wr3) begin
        start_q <= 1'b1;
      end
    end
  end

  // Length counter: disable beats load, load beats half-frame decrement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      length_q <= 8'd0;
    end else if (!i_channel_en) begin
      length_q <= 8'd0;
    end else if (wr3) begin
      length_q <= len_of(i_wr_data[7:3]);
    end else if (i_half_stb && (length_q != 8'd0) && !halt_q) begin
      length_q <= length_q - 8'd1;
    end
  end

  // Registered phase delta, one clock behind the period index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_phase_delta <= 32'd0;
    end else begin
      o_phase_delta <= delta_rom[period_idx_q];
    end
  end

  // Output volume selection from registered state.
  always_comb begin
    o_volume = 4'd0;
    if (length_q == 8'd0) begin
      o_volume = 4'd0;
    end else if (const_q) begin
      o_volume = vol_v_q;
    end else begin
      o_volume = decay_q;
    end
  end

  assign o_active = (length_q != 8'd0);
  assign o_mode   = mode_q;

endmodule

// File: tb/tb_channel_4_noise_controller.sv
// Directed bench for channel_4_noise_controller: register programming,
// phase delta, envelope decay/loop, length counter halt/load/disable, reset.
module tb_channel_4_noise_controller;

  localparam int CLK_HZ = 25_000_000;
  localparam int CPU_HZ = 1_789_773;

  logic        i_clk;
  logic        i_rst;
  logic        i_wr_stb;
  logic [1:0]  i_wr_addr;
  logic [7:0]  i_wr_data;
  logic        i_quarter_stb;
  logic        i_half_stb;
  logic        i_channel_en;
  logic [31:0] o_phase_delta;
  logic        o_mode;
  logic [3:0]  o_volume;
  logic        o_active;

  int n_cmp;
  int n_err;

  channel_4_noise_controller #(
    .CLK_HZ(CLK_HZ),
    .CPU_HZ(CPU_HZ)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_stb      (i_wr_stb),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .i_quarter_stb (i_quarter_stb),
    .i_half_stb    (i_half_stb),
    .i_channel_en  (i_channel_en),
    .o_phase_delta (o_phase_delta),
    .o_mode        (o_mode),
    .o_volume      (o_volume),
    .o_active      (o_active)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    i_wr_stb  = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    tick();
    i_wr_stb  = 1'b0;
  endtask

  task automatic quarter(input int n);
    for (int i = 0; i < n; i++) begin
      i_quarter_stb = 1'b1;
      tick();
      i_quarter_stb = 1'b0;
    end
  endtask

  task automatic half(input int n);
    for (int i = 0; i < n; i++) begin
      i_half_stb = 1'b1;
      tick();
      i_half_stb = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [63:0] delta15;

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Reference for P=15 (PERIOD=4068) from the delta formula.
    delta15 = ((64'd1 << 32) * 64'(CPU_HZ)) / (64'd4068 * 64'(CLK_HZ));

    i_rst = 1'b1;
    i_wr_stb = 1'b0;
    i_wr_addr = 2'd0;
    i_wr_data = 8'd0;
    i_quarter_stb = 1'b0;
    i_half_stb = 1'b0;
    i_channel_en = 1'b0;
    tick();
    tick();
    chk("reset_delta", o_phase_delta, 32'd0);
    chk("reset_volume", {28'd0, o_volume}, 32'd0);
    chk("reset_active", {31'd0, o_active}, 32'd0);
    chk("reset_mode", {31'd0, o_mode}, 32'd0);
    i_rst = 1'b0;

    // Phase delta and mode
    wr(2'd2, 8'h00);
    tick();
    chk("delta_p0", o_phase_delta, 32'd76_870_165);
    chk("mode_long", {31'd0, o_mode}, 32'd0);
    wr(2'd2, 8'h81);
    chk("mode_short", {31'd0, o_mode}, 32'd1);
    chk("delta_p1_not_yet", o_phase_delta, 32'd76_870_165);
    tick();
    chk("delta_p1", o_phase_delta, 32'd38_435_082);
    wr(2'd2, 8'h0F);
    tick();
    chk("delta_p15", o_phase_delta, delta15[31:0]);

    // Constant volume, long length index
    i_channel_en = 1'b1;
    wr(2'd0, 8'h1A);
    wr(2'd3, 8'h08);
    chk("len254_active", {31'd0, o_active}, 32'd1);
    chk("const_volume", {28'd0, o_volume}, 32'd10);
    half(253);
    chk("len254_one_left", {31'd0, o_active}, 32'd1);
    half(1);
    chk("len254_done_vol", {28'd0, o_volume}, 32'd0);
    chk("len254_done_act", {31'd0, o_active}, 32'd0);
    half(3);
    chk("len_saturate", {31'd0, o_active}, 32'd0);

    // Envelope decay, no loop, period 3
    wr(2'd0, 8'h03);
    wr(2'd3, 8'h00);
    quarter(1);
    chk("env_start", {28'd0, o_volume}, 32'd15);
    quarter(3);
    chk("env_hold15", {28'd0, o_volume}, 32'd15);
    quarter(1);
    chk("env_14", {28'd0, o_volume}, 32'd14);
    quarter(52);
    chk("env_1", {28'd0, o_volume}, 32'd1);
    quarter(4);
    chk("env_0", {28'd0, o_volume}, 32'd0);
    quarter(8);
    chk("env_hold0", {28'd0, o_volume}, 32'd0);

    // Envelope loop
    wr(2'd0, 8'h23);
    wr(2'd3, 8'h00);
    quarter(1);
    chk("loop_start", {28'd0, o_volume}, 32'd15);
    quarter(60);
    chk("loop_0", {28'd0, o_volume}, 32'd0);
    quarter(4);
    chk("loop_wrap", {28'd0, o_volume}, 32'd15);

    // Length halt, then release
    wr(2'd0, 8'h20);
    wr(2'd3, 8'h00);
    half(50);
    chk("halt_active", {31'd0, o_active}, 32'd1);
    wr(2'd0, 8'h00);
    half(9);
    chk("release_9", {31'd0, o_active}, 32'd1);
    half(1);
    chk("release_10", {31'd0, o_active}, 32'd0);

    // addr3 load coincident with half strobe: load wins
    wr(2'd0, 8'h15);
    i_half_stb = 1'b1;
    wr(2'd3, 8'h00);
    i_half_stb = 1'b0;
    chk("coinc_vol", {28'd0, o_volume}, 32'd5);
    half(9);
    chk("coinc_9", {31'd0, o_active}, 32'd1);
    half(1);
    chk("coinc_10", {31'd0, o_active}, 32'd0);

    // Channel disable
    wr(2'd3, 8'h00);
    chk("en_loaded", {31'd0, o_active}, 32'd1);
    i_channel_en = 1'b0;
    tick();
    chk("disable_clear", {31'd0, o_active}, 32'd0);
    wr(2'd3, 8'h08);
    chk("disable_blocks", {31'd0, o_active}, 32'd0);

    // Reset mid-envelope and mid-length
    i_channel_en = 1'b1;
    wr(2'd0, 8'h03);
    wr(2'd3, 8'h00);
    quarter(5);
    half(2);
    chk("pre_reset_vol", {28'd0, o_volume}, 32'd14);
    i_rst = 1'b1;
    i_quarter_stb = 1'b1;
    i_half_stb = 1'b1;
    tick();
    i_quarter_stb = 1'b0;
    i_half_stb = 1'b0;
    chk("rst_vol", {28'd0, o_volume}, 32'd0);
    chk("rst_active", {31'd0, o_active}, 32'd0);
    chk("rst_delta", o_phase_delta, 32'd0);
    chk("rst_mode", {31'd0, o_mode}, 32'd0);
    i_rst = 1'b0;
    tick();
    tick();
    chk("post_rst_delta", o_phase_delta, 32'd76_870_165);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/channel_4_noise_controller.md
Name: channel_4_noise_controller

Overview:
Register-programmed control unit for the noise channel. It holds the four NES-style noise registers and runs the envelope and length-counter units from frame-sequencer strobes. It drives the shift-register clock rate (phase delta), LFSR mode and 4-bit volume into the noise datapath. It sits between the CPU/sequencer write bus and the phase generator / LFSR / output stage.

Parameters:
CLK_HZ, 25_000_000, system clock frequency in Hz
CPU_HZ, 1_789_773, emulated APU clock in Hz; used only for elaboration-time constants

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_wr_stb  in  1  register write strobe, one cycle
i_wr_addr  in  2  register select 0..3
i_wr_data  in  8  write data
i_quarter_stb  in  1  quarter-frame strobe (envelope clock)
i_half_stb  in  1  half-frame strobe (length clock)
i_channel_en  in  1  channel enable (status-register bit)
o_phase_delta  out  32  phase increment for the phase generator
o_mode  out  1  LFSR mode bit (0 = long, 1 = short)
o_volume  out  4  channel volume to the output stage
o_active  out  1  length counter non-zero

Behaviour:
- Reset is synchronous on i_rst, active-high, clocked by i_clk. Reset clears all registers, the length counter, the decay level, the divider and the start flag. After reset: o_volume=0, o_active=0, o_mode=0, o_phase_delta=0.
- Register map:
  - addr0: [5]=halt/loop, [4]=constant-volume flag, [3:0]=V (volume or envelope period).
  - addr1: write ignored.
  - addr2: [7]=mode, [3:0]=period index P.
  - addr3: [7:3]=length index L. Writing addr3 sets the start flag. If i_channel_en=1, it also loads the length counter with LEN[L]. Bits [2:0] are ignored.
- Tables:
  - PERIOD[0..15] = 4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068.
  - DELTA[P] = floor(2^32*CPU_HZ/(PERIOD[P]*CLK_HZ)), computed at elaboration with 64-bit arithmetic.
  - LEN[0..31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- o_phase_delta is registered and equals DELTA[P] one clock after P changes. First valid value: 2nd clock after reset deasserts.
- o_mode is a direct register bit, visible the cycle after the write.
- Envelope unit, clocked only on i_quarter_stb:
  - Start flag set: clear start, decay=15, divider=V.
  - Else if divider==0: divider=V. Then if decay!=0, decay-1. Else if loop=1, decay=15. Else hold 0.
  - Else: divider-1.
- Length counter, clocked on i_half_stb: if length!=0 and halt=0, length-1. Saturates at 0; never wraps.
- i_channel_en=0 forces length=0 on that clock and blocks addr3 loads.
- o_volume (combinational from registered state):
  - 0 if length==0.
  - Else V if the constant flag is set.
  - Else decay.
  - Changes are visible the cycle after the causing edge.
- o_active = (length!=0).
- Simultaneous events:
  - addr3 write with i_half_stb: the load wins, no decrement that cycle.
  - addr3 write with i_quarter_stb: the quarter step uses the pre-write start flag. The new start flag is serviced at the next quarter strobe.
  - addr0 write with any strobe: the strobe uses the old register values.
  - i_channel_en=0 with an addr3 write: length=0.
  - i_quarter_stb and i_half_stb together: both units step independently.
- Reset asserted mid-envelope or mid-length: everything returns to reset state on that edge, regardless of strobes.

Test Plan:
- Reset, then write addr2=0x00 with defaults -> o_phase_delta=0 during reset; o_phase_delta=76_870_165 from 2nd clock after write; o_mode=0.
- en=1; addr0=0x1A (const, V=10); addr3=0x08 (L=1) -> o_active=1, o_volume=10. 254 half strobes -> o_volume=0, o_active=0 from next cycle. Extra half strobes keep length at 0.
- en=1; addr0=0x03 (envelope, V=3, no loop); addr3=0x00 (length 10) -> 1st quarter strobe gives o_volume=15. Decay then drops by 1 every 4 quarter strobes to 0 and holds. Repeat with addr0=0x23 (loop) -> wraps 0->15.
- addr0=0x20 (halt) with length 10 -> 50 half strobes leave o_active=1. Then addr0=0x00 -> 10 more half strobes give o_active=0.
- addr3 write coincident with i_half_stb, L=0 -> length=10, not 9. Drop i_channel_en -> o_active=0 next cycle. addr3 write while en=0 -> o_active stays 0.
- Assert i_rst during envelope decay with length mid-count -> next cycle o_volume=0, o_active=0, o_phase_delta=0.
